// File: rtl/fadd_sub_seq_ctrl.sv
// Sequencer for the FP add/sub datapath: walks align, add/sub, normalize and round,
// or takes the special-operand bypass, then holds the tagged result until the consumer takes it.
module fadd_sub_seq_ctrl #(
   parameter int TAG_W        = 5,
   parameter int NORM_TIMEOUT = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   output logic             ready_o,
   input  logic             op_sub_i,
   input  logic [TAG_W-1:0] rd_tag_i,
   input  logic             special_i,
   input  logic             flush_i,
   input  logic             norm_done_i,
   output logic             align_en_o,
   output logic             addsub_en_o,
   output logic             norm_en_o,
   output logic             round_en_o,
   output logic             special_sel_o,
   output logic             op_sub_o,
   output logic             valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   input  logic             result_ready_i,
   output logic             busy_o,
   output logic             norm_timeout_o
);

   localparam int CNT_W = $clog2(NORM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NORM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_SPECIAL, S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             op_sub_q;
   logic [TAG_W-1:0] tag_q;
   logic             special_q;
   logic             timeout_q;
   logic             accept;

   assign ready_o = (state_q == S_IDLE) & ~flush_i;
   assign accept  = start_i & ready_o;

   // Flush suppresses every enable and the result strobe in the cycle it is seen.
   assign align_en_o     = (state_q == S_ALIGN)  & ~flush_i;
   assign addsub_en_o    = (state_q == S_ADDSUB) & ~flush_i;
   assign norm_en_o      = (state_q == S_NORM)   & ~flush_i;
   assign round_en_o     = (state_q == S_ROUND)  & ~flush_i;
   assign valid_o        = (state_q == S_DONE)   & ~flush_i;
   assign special_sel_o  = (state_q == S_SPECIAL) | ((state_q == S_DONE) & special_q);
   assign busy_o         = (state_q != S_IDLE);
   assign op_sub_o       = op_sub_q;
   assign rd_tag_o       = tag_q;
   assign norm_timeout_o = timeout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_sub_q  <= 1'b0;
         tag_q     <= '0;
         special_q <= 1'b0;
         timeout_q <= 1'b0;
      end else if (flush_i && state_q != S_IDLE) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_sub_q  <= op_sub_i;
                  tag_q     <= rd_tag_i;
                  special_q <= special_i;
                  timeout_q <= 1'b0;
                  state_q   <= special_i ? S_SPECIAL : S_ALIGN;
               end
            end
            S_ALIGN:  state_q <= S_ADDSUB;
            S_ADDSUB: begin
               cnt_q   <= '0;
               state_q <= S_NORM;
            end
            S_NORM: begin
               cnt_q <= cnt_q + 1'b1;
               if (norm_done_i) begin
                  state_q <= S_ROUND;
               end else if (cnt_q == CNT_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_ROUND;
               end
            end
            S_ROUND:   state_q <= S_DONE;
            S_SPECIAL: state_q <= S_DONE;
            S_DONE:    if (result_ready_i) state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

endmodule
